// File: rtl/width_change_pkg.sv
// Shared constants for the width_change_8to12 / width_change_12to8 converter pair.
package width_change_pkg;

    localparam int unsigned WC_AWIDTH = 12;
    localparam int unsigned WC_BWIDTH = 8;
    localparam int unsigned WC_BUF_W  = 24;
    localparam int unsigned WC_CNT_W  = 5;

endpackage

// File: rtl/width_change_12to8.sv
// 12-bit to 8-bit stream width converter with a 24-bit left-aligned bit buffer.
// Define WIDTH_CHANGE_OVF_EN to compile in the sticky overflow flag for dropped words.
module width_change_12to8
    import width_change_pkg::*;
#(
    parameter int unsigned AWIDTH = WC_AWIDTH,
    parameter int unsigned BWIDTH = WC_BWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_vld,
    input  logic [AWIDTH-1:0] a,
    output logic              b_vld,
    output logic [BWIDTH-1:0] b,
    output logic              ovf
);

    localparam int unsigned BUF_W = WC_BUF_W;
    localparam int unsigned CNT_W = WC_CNT_W;

    logic [BUF_W-1:0] bits_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BUF_W-1:0] a_al;
    logic [BUF_W-1:0] merged;
    logic [CNT_W-1:0] total;
    logic             accept;

    // A word fits only if it can be appended behind the valid bits without spilling.
    always_comb begin
        accept = a_vld && (cnt_q <= CNT_W'(BUF_W - AWIDTH));
        a_al   = BUF_W'(a) << (BUF_W - AWIDTH);
        merged = bits_q | (accept ? (a_al >> cnt_q) : '0);
        total  = cnt_q + (accept ? CNT_W'(AWIDTH) : CNT_W'(0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q <= '0;
            cnt_q  <= '0;
            b      <= '0;
            b_vld  <= 1'b0;
        end else if (total >= CNT_W'(BWIDTH)) begin
            b      <= merged[BUF_W-1 -: BWIDTH];
            bits_q <= merged << BWIDTH;
            cnt_q  <= total - CNT_W'(BWIDTH);
            b_vld  <= 1'b1;
        end else begin
            bits_q <= merged;
            cnt_q  <= total;
            b_vld  <= 1'b0;
        end
    end

`ifdef WIDTH_CHANGE_OVF_EN
    logic drop;

    assign drop = a_vld && !accept;

    // Sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_width_change_12to8.sv
// Directed self-checking bench for width_change_12to8; expected bytes are hand-derived.
module tb_width_change_12to8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_vld;
    logic [11:0] a;
    logic        b_vld;
    logic [7:0]  b;
    logic        ovf;

    int total = 0;
    int bad   = 0;

`ifdef WIDTH_CHANGE_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    width_change_12to8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a_vld (a_vld),
        .a     (a),
        .b_vld (b_vld),
        .b     (b),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_vld = 1'b0;
        a     = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        a_vld = 1'b0;
        a     = '0;
        rst_n = 1'b0;
        #3;
        total++;
        if (b_vld !== 1'b0) begin bad++; $display("FAIL reset_b_vld got=%b want=0", b_vld); end
        total++;
        if (b !== 8'h00) begin bad++; $display("FAIL reset_b got=%h want=00", b); end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (b_vld !== 1'b0) begin bad++; $display("FAIL reset_idle_b_vld got=%b want=0", b_vld); end
    endtask

    task automatic test_pair();
        logic        vin [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [11:0] win [4] = '{12'hAAB, 12'hBCC, 12'h000, 12'h000};
        logic        ev  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]  eb  [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hCC};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_vld = vin[i];
            a     = win[i];
            tick();
            total++;
            if (b_vld !== ev[i]) begin bad++; $display("FAIL pair_b_vld[%0d] got=%b want=%b", i, b_vld, ev[i]); end
            total++;
            if (b !== eb[i]) begin bad++; $display("FAIL pair_b[%0d] got=%h want=%h", i, b, eb[i]); end
        end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL pair_ovf got=%b want=0", ovf); end
    endtask

    task automatic test_idle_residue();
        logic        vin [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [11:0] win [8] = '{12'h55A, 12'h000, 12'h000, 12'h000, 12'h000, 12'h123, 12'h000, 12'h000};
        logic        ev  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0]  eb  [8] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hA1, 8'h23, 8'h23};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a_vld = vin[i];
            a     = win[i];
            tick();
            total++;
            if (b_vld !== ev[i]) begin bad++; $display("FAIL idle_b_vld[%0d] got=%b want=%b", i, b_vld, ev[i]); end
            total++;
            if (b !== eb[i]) begin bad++; $display("FAIL idle_b[%0d] got=%h want=%h", i, b, eb[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [11:0] win [5] = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
        logic [7:0]  eb  [7] = '{8'h11, 8'h12, 8'h22, 8'h33, 8'h34, 8'h44, 8'h44};
        logic        ev  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            a_vld = (i < 5);
            a     = (i < 5) ? win[i] : 12'h000;
            tick();
            total++;
            if (b_vld !== ev[i]) begin bad++; $display("FAIL ovf_b_vld[%0d] got=%b want=%b", i, b_vld, ev[i]); end
            total++;
            if (b !== eb[i]) begin bad++; $display("FAIL ovf_b[%0d] got=%h want=%h", i, b, eb[i]); end
            if (i == 3) begin
                total++;
                if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_before_drop got=%b want=0", ovf); end
            end
        end
        total++;
        if (ovf !== OVF_EXP) begin bad++; $display("FAIL ovf_sticky got=%b want=%b", ovf, OVF_EXP); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        a_vld = 1'b1;
        a     = 12'h55A;
        tick();
        total++;
        if (b !== 8'h55 || b_vld !== 1'b1) begin bad++; $display("FAIL mrst_pre got=%b/%h want=1/55", b_vld, b); end
        a_vld = 1'b0;
        a     = '0;
        rst_n = 1'b0;
        #2;
        total++;
        if (b !== 8'h00) begin bad++; $display("FAIL mrst_b got=%h want=00", b); end
        total++;
        if (b_vld !== 1'b0) begin bad++; $display("FAIL mrst_b_vld got=%b want=0", b_vld); end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL mrst_ovf got=%b want=0", ovf); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        a_vld = 1'b1;
        a     = 12'hBCC;
        tick();
        total++;
        if (b_vld !== 1'b1) begin bad++; $display("FAIL mrst_first_vld got=%b want=1", b_vld); end
        total++;
        if (b !== 8'hBC) begin bad++; $display("FAIL mrst_first_b got=%h want=bc", b); end
        a_vld = 1'b0;
        a     = '0;
        tick();
        total++;
        if (b_vld !== 1'b0) begin bad++; $display("FAIL mrst_residue_vld got=%b want=0", b_vld); end
    endtask

    // Upstream 8-to-12 packer modelled as two words per three bytes, issued at 2-of-3 cadence.
    task automatic test_upstream_chain();
        logic [7:0]  bytes [6] = '{8'h55, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        logic [11:0] words [4];
        logic        vin   [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int          wi = 0;
        for (int g = 0; g < 2; g++) begin
            words[2*g]   = {bytes[3*g], bytes[3*g+1][7:4]};
            words[2*g+1] = {bytes[3*g+1][3:0], bytes[3*g+2]};
        end
        do_reset();
        for (int i = 0; i < 7; i++) begin
            a_vld = vin[i];
            a     = vin[i] ? words[wi] : 12'h000;
            if (vin[i]) wi++;
            tick();
            if (i < 6) begin
                total++;
                if (b_vld !== 1'b1 || b !== bytes[i]) begin
                    bad++;
                    $display("FAIL chain_byte[%0d] got=%b/%h want=1/%h", i, b_vld, b, bytes[i]);
                end
            end else begin
                total++;
                if (b_vld !== 1'b0) begin bad++; $display("FAIL chain_tail_vld got=%b want=0", b_vld); end
            end
        end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL chain_ovf got=%b want=0", ovf); end
    endtask

    initial begin
        rst_n = 1'b0;
        a_vld = 1'b0;
        a     = '0;
        test_reset();
        test_pair();
        test_idle_residue();
        test_overflow();
        test_mid_reset();
        test_upstream_chain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
